// File: rtl/mcu_scheduler_if.sv
// Bundles the configuration, datapath handshake and status signals of mcu_scheduler.
// stall_cycles exists only when MCU_SCHED_PERF_EN is defined.
interface mcu_scheduler_if #(
    parameter int CH    = 3,
    parameter int MCU_W = 16
);
    localparam int CHW = $clog2(CH + 1);

    logic [1:0]       cfg_mode;
    logic [MCU_W-1:0] cfg_num_mcus;
    logic [MCU_W-1:0] cfg_rst_intv;
    logic             start;
    logic             sym_valid;
    logic             block_done;
    logic             rmark_ack;

    logic [CHW-1:0]   ch;
    logic             freq;
    logic             dc_clr;
    logic             rmark_req;
    logic             dec_en;
    logic [MCU_W-1:0] mcu_idx;
    logic             busy;
    logic             done;
`ifdef MCU_SCHED_PERF_EN
    logic [31:0]      stall_cycles;
`endif

    modport master (
`ifdef MCU_SCHED_PERF_EN
        input  stall_cycles,
`endif
        output cfg_mode, cfg_num_mcus, cfg_rst_intv, start,
        output sym_valid, block_done, rmark_ack,
        input  ch, freq, dc_clr, rmark_req, dec_en, mcu_idx, busy, done
    );

    modport slave (
`ifdef MCU_SCHED_PERF_EN
        output stall_cycles,
`endif
        input  cfg_mode, cfg_num_mcus, cfg_rst_intv, start,
        input  sym_valid, block_done, rmark_ack,
        output ch, freq, dc_clr, rmark_req, dec_en, mcu_idx, busy, done
    );
endinterface

// File: rtl/mcu_scheduler.sv
// Block/MCU/scan sequencer for the entropy decoder with restart-interval handling.
// Optional stall counter enabled by defining MCU_SCHED_PERF_EN.
module mcu_scheduler #(
    parameter int CH    = 3,
    parameter int MCU_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    mcu_scheduler_if.slave bus
);
    localparam int CHW = $clog2(CH + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DC      = 3'd1;
    localparam logic [2:0] S_AC      = 3'd2;
    localparam logic [2:0] S_MCU_END = 3'd3;
    localparam logic [2:0] S_RMARK   = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    logic [2:0]       state, state_nxt;
    logic [1:0]       mode_q;
    logic [MCU_W-1:0] num_q, intv_q;
    logic [MCU_W-1:0] intv_cnt, mcu_idx_q;
    logic [2:0]       blk_cnt, blk_nxt;
    logic [CHW-1:0]   ch_q;

    logic             start_ok, blk_end, blk_last, mcu_last, intv_hit;
    logic [MCU_W-1:0] mcu_inc, intv_inc;

    function automatic logic [2:0] last_blk(input logic [1:0] m);
        case (m)
            2'd1:    return 3'd2;
            2'd2:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    // Component order: 4:4:4 is Y,Cb,Cr; 4:2:0 is four Y then Cb,Cr.
    function automatic logic [CHW-1:0] ch_of(input logic [1:0] m, input logic [2:0] b);
        case (m)
            2'd1:    return CHW'(b);
            2'd2:    return (b == 3'd4) ? CHW'(1) : (b == 3'd5) ? CHW'(2) : CHW'(0);
            default: return CHW'(0);
        endcase
    endfunction

    assign start_ok = (state == S_IDLE) && bus.start;
    // A DC-only block (EOB in the same cycle as the DC symbol) finishes straight from DC.
    assign blk_end  = bus.block_done &&
                      ((state == S_AC) || ((state == S_DC) && bus.sym_valid));
    assign blk_last = (blk_cnt == last_blk(mode_q));
    assign blk_nxt  = blk_last ? 3'd0 : 3'(blk_cnt + 3'd1);
    assign mcu_inc  = mcu_idx_q + MCU_W'(1);
    assign intv_inc = intv_cnt + MCU_W'(1);
    assign mcu_last = (mcu_inc == num_q);
    assign intv_hit = (intv_q != '0) && (intv_inc == intv_q);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:    if (bus.start) state_nxt = (bus.cfg_num_mcus == '0) ? S_FIN : S_DC;
            S_DC:      if (blk_end)            state_nxt = blk_last ? S_MCU_END : S_DC;
                       else if (bus.sym_valid) state_nxt = S_AC;
            S_AC:      if (blk_end) state_nxt = blk_last ? S_MCU_END : S_DC;
            S_MCU_END: state_nxt = mcu_last ? S_FIN : (intv_hit ? S_RMARK : S_DC);
            S_RMARK:   if (bus.rmark_ack) state_nxt = S_DC;
            S_FIN:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            mode_q    <= 2'd0;
            num_q     <= '0;
            intv_q    <= '0;
            intv_cnt  <= '0;
            mcu_idx_q <= '0;
            blk_cnt   <= 3'd0;
            ch_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            if (start_ok) begin
                mode_q    <= (bus.cfg_mode == 2'd3) ? 2'd0 : bus.cfg_mode;
                num_q     <= bus.cfg_num_mcus;
                intv_q    <= bus.cfg_rst_intv;
                intv_cnt  <= '0;
                mcu_idx_q <= '0;
                blk_cnt   <= 3'd0;
                ch_q      <= '0;
            end
            if (blk_end) begin
                blk_cnt <= blk_nxt;
                ch_q    <= ch_of(mode_q, blk_nxt);
            end
            if (state == S_MCU_END) begin
                mcu_idx_q <= mcu_inc;
                intv_cnt  <= intv_inc;
                blk_cnt   <= 3'd0;
            end
            if ((state == S_RMARK) && bus.rmark_ack) intv_cnt <= '0;
        end
    end

    assign bus.ch        = ch_q;
    assign bus.freq      = (state == S_AC);
    assign bus.dec_en    = (state == S_DC) || (state == S_AC);
    assign bus.dc_clr    = (start_ok && (bus.cfg_num_mcus != '0)) ||
                           ((state == S_RMARK) && bus.rmark_ack);
    assign bus.rmark_req = (state == S_RMARK);
    assign bus.mcu_idx   = mcu_idx_q;
    // The completion cycle reports done with busy already low.
    assign bus.busy      = (state != S_IDLE) && (state != S_FIN);
    assign bus.done      = (state == S_FIN);

`ifdef MCU_SCHED_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if (((state == S_MCU_END) || (state == S_RMARK)) && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_mcu_scheduler.sv
// Directed self-checking bench for mcu_scheduler: 4:2:0 scan, restarts, empty scan,
// DC-only blocks and asynchronous reset mid-scan.
module tb_mcu_scheduler;
    localparam int CH    = 3;
    localparam int MCU_W = 16;

    typedef struct {
        bit         reached;
        logic [1:0] ch;
        logic       freq_dc;
        logic       freq_ac;
        logic       en_ac;
    } blk_obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    int   dc_cnt = 0, done_cnt = 0, rreq_rise = 0, act_cnt = 0, freq_cnt = 0;
    logic rreq_d = 1'b0;

    mcu_scheduler_if #(.CH(CH), .MCU_W(MCU_W)) bus ();

    mcu_scheduler #(.CH(CH), .MCU_W(MCU_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Mid-cycle event counters (inputs change on the falling edge).
    always begin
        @(negedge clk);
        #2;
        if (bus.dc_clr) dc_cnt++;
        if (bus.done) done_cnt++;
        if (bus.rmark_req && !rreq_d) rreq_rise++;
        rreq_d = bus.rmark_req;
        if (bus.freq || bus.dec_en) act_cnt++;
        if (bus.freq) freq_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_scan(input logic [1:0] m, input int n, input int iv, output logic dcs);
        bus.cfg_mode     = m;
        bus.cfg_num_mcus = MCU_W'(n);
        bus.cfg_rst_intv = MCU_W'(iv);
        bus.start        = 1'b1;
        #1 dcs = bus.dc_clr;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_dc(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.dec_en === 1'b1 && bus.freq === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // DC symbol, then block_done gap cycles later (gap 0 = same cycle).
    task automatic do_block(input int gap, output blk_obs_t o);
        wait_dc(o.reached);
        o.ch      = bus.ch;
        o.freq_dc = bus.freq;
        bus.sym_valid = 1'b1;
        if (gap == 0) bus.block_done = 1'b1;
        tick();
        bus.sym_valid  = 1'b0;
        bus.block_done = 1'b0;
        o.freq_ac = bus.freq;
        o.en_ac   = bus.dec_en;
        if (gap > 0) begin
            repeat (gap - 1) tick();
            bus.block_done = 1'b1;
            tick();
            bus.block_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [22:0] outs;
        #3;
        outs = {bus.ch, bus.freq, bus.dc_clr, bus.rmark_req, bus.dec_en, bus.mcu_idx, bus.busy, bus.done};
        vectors++;
        if (outs !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.dec_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b dec_en=%b expected 0 0", bus.busy, bus.dec_en);
        end
    endtask

    task automatic test_420_scan();
        logic [1:0] exp_ch [12] = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 2};
        blk_obs_t o;
        logic dcs;
        bit ok;
        int b_dc = dc_cnt, b_done = done_cnt;
        start_scan(2'd2, 2, 0, dcs);
        vectors++;
        if (dcs !== 1'b1) begin
            miscompares++;
            $display("FAIL s420_dc_clr_start: got %b expected 1", dcs);
        end
        for (int b = 0; b < 12; b++) begin
            do_block(5, o);
            vectors++;
            if (o.ch !== exp_ch[b]) begin
                miscompares++;
                $display("FAIL s420_ch blk%0d: got %0d expected %0d", b, o.ch, exp_ch[b]);
            end
            vectors++;
            if ({o.reached, o.freq_dc, o.freq_ac, o.en_ac} !== 4'b1011) begin
                miscompares++;
                $display("FAIL s420_freq blk%0d: got %b expected 1011",
                         b, {o.reached, o.freq_dc, o.freq_ac, o.en_ac});
            end
        end
        wait_done(ok);
        vectors++;
        if (!ok || bus.mcu_idx !== 16'd2) begin
            miscompares++;
            $display("FAIL s420_done: done_seen=%0d mcu_idx=%0d expected 1 2", ok, bus.mcu_idx);
        end
        tick();
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.mcu_idx !== 16'd2) begin
            miscompares++;
            $display("FAIL s420_idle: done=%b busy=%b mcu_idx=%0d expected 0 0 2",
                     bus.done, bus.busy, bus.mcu_idx);
        end
        vectors++;
        if (dc_cnt - b_dc !== 1 || done_cnt - b_done !== 1) begin
            miscompares++;
            $display("FAIL s420_pulses: dc_clr=%0d done=%0d expected 1 1",
                     dc_cnt - b_dc, done_cnt - b_done);
        end
    endtask

    task automatic test_restart();
        blk_obs_t o;
        logic dcs;
        bit ok;
        bit bad;
        int b_dc = dc_cnt, b_rr = rreq_rise;
        start_scan(2'd1, 4, 2, dcs);
        for (int b = 0; b < 12; b++) begin
            if (b == 6) begin
                ok = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    if (bus.rmark_req === 1'b1) begin
                        ok = 1'b1;
                        break;
                    end
                    tick();
                end
                vectors++;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL rst_req_rise: rmark_req=%b expected 1", bus.rmark_req);
                end
                bad = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    if (bus.dec_en !== 1'b0 || bus.rmark_req !== 1'b1) bad = 1'b1;
                    tick();
                end
                vectors++;
                if (bad) begin
                    miscompares++;
                    $display("FAIL rst_hold: got dec_en/rmark_req wrong during wait, expected 0/1");
                end
                bus.rmark_ack = 1'b1;
                #1;
                vectors++;
                if (bus.dc_clr !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rst_ack_dc_clr: got %b expected 1", bus.dc_clr);
                end
                tick();
                bus.rmark_ack = 1'b0;
                vectors++;
                if ({bus.rmark_req, bus.dec_en, bus.freq, bus.ch} !== 5'b01000) begin
                    miscompares++;
                    $display("FAIL rst_resume: got %b expected 01000",
                             {bus.rmark_req, bus.dec_en, bus.freq, bus.ch});
                end
            end
            do_block(2, o);
            vectors++;
            if (o.ch !== 2'(b % 3) || !o.reached) begin
                miscompares++;
                $display("FAIL rst_ch blk%0d: got %0d expected %0d", b, o.ch, b % 3);
            end
        end
        wait_done(ok);
        vectors++;
        if (!ok || bus.mcu_idx !== 16'd4) begin
            miscompares++;
            $display("FAIL rst_done: done_seen=%0d mcu_idx=%0d expected 1 4", ok, bus.mcu_idx);
        end
`ifdef MCU_SCHED_PERF_EN
        vectors++;
        if (bus.stall_cycles !== 32'd15) begin
            miscompares++;
            $display("FAIL rst_stall_cycles: got %0d expected 15", bus.stall_cycles);
        end
`endif
        tick();
        vectors++;
        if (rreq_rise - b_rr !== 1 || dc_cnt - b_dc !== 2) begin
            miscompares++;
            $display("FAIL rst_pulses: rmark_req rises=%0d dc_clr=%0d expected 1 2",
                     rreq_rise - b_rr, dc_cnt - b_dc);
        end
    endtask

    task automatic test_empty_scan();
        logic dcs;
        int b_act = act_cnt, b_done = done_cnt;
        start_scan(2'd0, 0, 0, dcs);
        vectors++;
        if (dcs !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_dc_clr: got %b expected 0", dcs);
        end
        vectors++;
        if ({bus.done, bus.dec_en, bus.freq, bus.mcu_idx} !== {3'b100, 16'd0}) begin
            miscompares++;
            $display("FAIL empty_done: done=%b dec_en=%b freq=%b mcu_idx=%0d expected 1 0 0 0",
                     bus.done, bus.dec_en, bus.freq, bus.mcu_idx);
        end
        tick();
        tick();
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || act_cnt - b_act !== 0 || done_cnt - b_done !== 1) begin
            miscompares++;
            $display("FAIL empty_after: done=%b busy=%b active_cycles=%0d done_pulses=%0d expected 0 0 0 1",
                     bus.done, bus.busy, act_cnt - b_act, done_cnt - b_done);
        end
    endtask

    task automatic test_dc_only();
        blk_obs_t o;
        logic dcs;
        bit ok;
        int b_freq = freq_cnt;
        start_scan(2'd0, 3, 0, dcs);
        for (int b = 0; b < 3; b++) begin
            do_block(0, o);
            vectors++;
            if ({o.reached, o.ch, o.freq_dc, o.freq_ac, o.en_ac} !== 6'b100000) begin
                miscompares++;
                $display("FAIL dconly blk%0d: got %b expected 100000",
                         b, {o.reached, o.ch, o.freq_dc, o.freq_ac, o.en_ac});
            end
        end
        wait_done(ok);
        vectors++;
        if (!ok || bus.mcu_idx !== 16'd3 || freq_cnt - b_freq !== 0) begin
            miscompares++;
            $display("FAIL dconly_done: done_seen=%0d mcu_idx=%0d ac_cycles=%0d expected 1 3 0",
                     ok, bus.mcu_idx, freq_cnt - b_freq);
        end
        tick();
    endtask

    task automatic test_async_reset();
        logic [1:0] exp_ch [12] = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 2};
        blk_obs_t o;
        logic dcs;
        bit ok;
        logic [22:0] outs;
        start_scan(2'd2, 2, 0, dcs);
        for (int b = 0; b < 11; b++) do_block(1, o);
        wait_dc(ok);
        bus.sym_valid = 1'b1;
        tick();
        bus.sym_valid = 1'b0;
        vectors++;
        if ({bus.freq, bus.ch, bus.mcu_idx} !== {1'b1, 2'd2, 16'd1}) begin
            miscompares++;
            $display("FAIL areset_pre: freq=%b ch=%0d mcu_idx=%0d expected 1 2 1",
                     bus.freq, bus.ch, bus.mcu_idx);
        end
        #2 rst = 1'b0;
        #1;
        outs = {bus.ch, bus.freq, bus.dc_clr, bus.rmark_req, bus.dec_en, bus.mcu_idx, bus.busy, bus.done};
        vectors++;
        if (outs !== 23'd0) begin
            miscompares++;
            $display("FAIL areset_outputs: got %h expected 0", outs);
        end
        tick();
        rst = 1'b1;
        tick();
        start_scan(2'd2, 2, 0, dcs);
        vectors++;
        if ({bus.ch, bus.mcu_idx, bus.dec_en, bus.busy, dcs} !== {2'd0, 16'd0, 3'b111}) begin
            miscompares++;
            $display("FAIL areset_restart: ch=%0d mcu_idx=%0d dec_en=%b busy=%b dc_clr=%b expected 0 0 1 1 1",
                     bus.ch, bus.mcu_idx, bus.dec_en, bus.busy, dcs);
        end
        for (int b = 0; b < 12; b++) begin
            do_block(1, o);
            vectors++;
            if (o.ch !== exp_ch[b]) begin
                miscompares++;
                $display("FAIL areset_ch blk%0d: got %0d expected %0d", b, o.ch, exp_ch[b]);
            end
        end
        wait_done(ok);
        vectors++;
        if (!ok || bus.mcu_idx !== 16'd2) begin
            miscompares++;
            $display("FAIL areset_done: done_seen=%0d mcu_idx=%0d expected 1 2", ok, bus.mcu_idx);
        end
        tick();
    endtask

    initial begin
        bus.cfg_mode     = 2'd0;
        bus.cfg_num_mcus = '0;
        bus.cfg_rst_intv = '0;
        bus.start        = 1'b0;
        bus.sym_valid    = 1'b0;
        bus.block_done   = 1'b0;
        bus.rmark_ack    = 1'b0;
        test_reset();
        test_420_scan();
        test_restart();
        test_empty_scan();
        test_dc_only();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
